// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the M-extension multiply/divide unit: FSM states,
// funct3 encodings and small decode helpers.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam logic [2:0] FUNCT3_ALU_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_ALU_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_ALU_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_ALU_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_ALU_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_ALU_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_ALU_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_ALU_REMU   = 3'b111;

  // Divide-family ops (DIV, DIVU, REM, REMU) all have bit 2 set.
  function automatic logic op_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic op_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // operand_a is treated as signed for MULH, MULHSU, DIV and REM.
  function automatic logic op_signed_a(input logic [2:0] f3);
    return (f3 == FUNCT3_ALU_MULH) || (f3 == FUNCT3_ALU_MULHSU) ||
           (f3 == FUNCT3_ALU_DIV)  || (f3 == FUNCT3_ALU_REM);
  endfunction

  // operand_b is treated as signed for MULH, DIV and REM.
  function automatic logic op_signed_b(input logic [2:0] f3);
    return (f3 == FUNCT3_ALU_MULH) || (f3 == FUNCT3_ALU_DIV) ||
           (f3 == FUNCT3_ALU_REM);
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: magnitude load, one shift-add or
// restoring shift-subtract step per cycle, and sign fix-up of the result.
module muldiv_datapath
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic [XLEN-1:0] fixed_result
);

  logic [2:0]        op_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic [XLEN-1:0]   opnd_q;
  logic              prod_neg_q;
  logic              quo_neg_q;
  logic              rem_neg_q;

  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [2*XLEN-1:0] prod_fixed;

  // Operand magnitudes, the per-iteration adder/subtractor and the sign fix-up.
  // NOTE: every always_comb output gets a value on every path (defaults or
  // full if/else and case-with-default) so no latch is inferred.
  always_comb begin
    a_neg     = op_signed_a(funct3) && operand_a[XLEN-1];
    b_neg     = op_signed_b(funct3) && operand_b[XLEN-1];
    mag_a     = a_neg ? -operand_a : operand_a;
    mag_b     = b_neg ? -operand_b : operand_b;
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    // When div_ge holds the difference is below the divisor, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - opnd_q;
    prod_fixed = prod_neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    case (op_q)
      FUNCT3_ALU_MUL:    fixed_result = prod_fixed[XLEN-1:0];
      FUNCT3_ALU_MULH,
      FUNCT3_ALU_MULHSU,
      FUNCT3_ALU_MULHU:  fixed_result = prod_fixed[2*XLEN-1:XLEN];
      FUNCT3_ALU_DIV,
      FUNCT3_ALU_DIVU:   fixed_result = quo_neg_q ? -lo_q : lo_q;
      default:           fixed_result = rem_neg_q ? -hi_q : hi_q;
    endcase
  end

  // Load magnitudes on acceptance, then iterate one bit per step.
  // NOTE: these working registers have no reset; each operation fully
  // reloads them before any value reaches the result register.
  always_ff @(posedge clock) begin
    if (load) begin
      op_q       <= funct3;
      hi_q       <= '0;
      lo_q       <= op_is_div(funct3) ? mag_a : mag_b;
      opnd_q     <= op_is_div(funct3) ? mag_b : mag_a;
      prod_neg_q <= !op_is_div(funct3) && (a_neg ^ b_neg);
      quo_neg_q  <= op_is_div(funct3) && (a_neg ^ b_neg);
      rem_neg_q  <= op_is_div(funct3) && a_neg;
    end else if (step) begin
      if (op_is_div(op_q)) begin
        hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], div_ge};
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit: handshake, FSM, iteration
// counter, special-case division results and the result register.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  muldiv_state_e   state_q;
  muldiv_state_e   state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] result_q;
  logic            dp_load;
  logic            dp_step;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_value;
  logic [XLEN-1:0] fixed_result;

  muldiv_datapath #(.XLEN(XLEN)) u_datapath (
    .clock        (clock),
    .load         (dp_load),
    .step         (dp_step),
    .funct3       (funct3),
    .operand_a    (operand_a),
    .operand_b    (operand_b),
    .fixed_result (fixed_result)
  );

  // Detect divide-by-zero and signed overflow on the incoming request.
  always_comb begin
    div_zero = op_is_div(funct3) && (operand_b == '0);
    div_ovf  = ((funct3 == FUNCT3_ALU_DIV) || (funct3 == FUNCT3_ALU_REM)) &&
               (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_value = op_is_rem(funct3) ? operand_a : '1;
    else          special_value = op_is_rem(funct3) ? '0 : operand_a;
  end

  // State register; reset wins over any handshake in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake/datapath controls.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dp_load   = 1'b0;
    dp_step   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (special) begin
            state_d = DONE;
          end else begin
            dp_load = 1'b1;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        dp_step = 1'b1;
        if (cnt_q == LAST_ITER) state_d = FIX;
      end
      FIX:  state_d = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Iteration counter: counts CALC cycles, idles at zero elsewhere.
  always_ff @(posedge clock) begin
    if (reset)                                 cnt_q <= '0;
    else if (state_q == CALC && cnt_q != LAST_ITER) cnt_q <= cnt_q + 1'b1;
    else                                       cnt_q <= '0;
  end

  // Result register: loaded for special cases on acceptance or after FIX.
  always_ff @(posedge clock) begin
    if (reset)                                      result_q <= '0;
    else if (state_q == IDLE && in_valid && special) result_q <= special_value;
    else if (state_q == FIX)                        result_q <= fixed_result;
  end

  assign result = result_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (any even value >= 8).
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port funct3  input  3  M-extension op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (RISC-V encoding).
REQ-007 SHALL have port operand_a  input  XLEN  rs1 value (dividend or multiplicand).
REQ-008 SHALL have port operand_b  input  XLEN  rs2 value (divisor or multiplier).
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  XLEN  operation result.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL drive in_ready high only in IDLE; acceptance is the cycle in which in_valid && in_ready.
REQ-014 SHALL register funct3, operand_a and operand_b on acceptance; later input changes do not affect the operation.
REQ-015 SHALL move IDLE->CALC on acceptance, except for special division cases, which move IDLE->DONE.
REQ-016 SHALL run CALC for exactly XLEN cycles, one bit per cycle: shift-add for multiply, restoring shift-subtract for divide. Operands are magnitudes; signedness comes from funct3: MULH, DIV and REM sign both operands; MULHSU signs operand_a only.
REQ-017 SHALL go CALC->FIX after the XLEN-th iteration. FIX spends one cycle negating product/quotient/remainder as sign rules require, then goes to DONE.
REQ-018 SHALL raise out_valid exactly XLEN+2 cycles after acceptance for normal operations, and 1 cycle after acceptance for special cases.
REQ-019 SHALL return bits [XLEN-1:0] of the 2*XLEN product for MUL, and bits [2*XLEN-1:XLEN] for MULH, MULHSU and MULHU.
REQ-020 SHALL give the remainder the sign of the dividend (truncating division).
REQ-021 SHALL, on divisor zero, return all-ones for DIV/DIVU and operand_a for REM/REMU.
REQ-022 SHALL, for DIV/REM with operand_a = -2^(XLEN-1) and operand_b = -1, return operand_a for DIV and 0 for REM.
REQ-023 SHALL hold out_valid and result stable in DONE until out_ready; on out_valid && out_ready, go to IDLE next cycle. There is no back-to-back acceptance in DONE.
REQ-024 SHALL keep result at its last value when out_valid is low.
REQ-025 SHALL map unused funct3 encodings to none, since all eight are defined; no X may propagate to result.

Reset
REQ-026 SHALL, when reset is high at a clock edge, force state IDLE, out_valid 0, result 0 and the iteration counter 0 in the next cycle, regardless of state.
REQ-027 SHALL drop an operation in flight at reset with no output, and accept a new request in the first cycle after reset deasserts.
REQ-028 SHALL give reset priority over a simultaneous in_valid or out_ready.

Structure
REQ-029 SHALL place the FSM state enum and the M-extension funct3 constants (FUNCT3_ALU_MUL..REMU) in the shared constants package; the ALU controller and this unit both use them.
REQ-030 SHALL keep the FSM, counter and handshake in muldiv_unit.
REQ-031 SHALL place the accumulator/shift registers and add/subtract step in one sub-module, muldiv_datapath, parametrised by XLEN.

Verification (XLEN=32)
REQ-032 SHALL cover: MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB, with out_valid exactly 34 cycles after acceptance.
REQ-033 SHALL cover: MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-034 SHALL cover: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU -> 2.
REQ-035 SHALL cover: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM -> 0. Each with out_valid at acceptance+1.
REQ-036 SHALL cover: out_ready held low 10 cycles after out_valid, with result and out_valid stable and in_ready low throughout; out_ready high for one cycle, then in_ready high the next cycle.
REQ-037 SHALL cover: reset asserted in CALC cycle 15, then out_valid is never raised and in_ready is high the cycle after reset deasserts; a new MUL 3 x 4 then returns 12.
